// File: rtl/throttle_ctrl.sv
// Cruise-control throttle stepper: debounced up/down walk of an 8-bit throttle
// command from a one-hot L/EQ/G comparator. Optional macro: THROTTLE_SOFT_RELEASE_EN.
module throttle_ctrl #(
    parameter int unsigned STEP = 1,
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       brake,
    input  logic [7:0] set_thr,
    input  logic       L,
    input  logic       EQ,
    input  logic       G,
    output logic [7:0] throttle,
    output logic [2:0] state,
    output logic       active,
    output logic       at_speed
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_HOLD    = 3'd1,
        ST_ACCEL   = 3'd2,
        ST_DECEL   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t     state_reg;
    logic [7:0] throttle_reg;
    logic [7:0] cnt_reg;

    state_t     dir;
    logic [8:0] up_sum;
    logic [8:0] dn_diff;
    logic [7:0] up_sat;
    logic [7:0] dn_sat;
    logic [8:0] cnt_inc;

    // Anything other than a clean one-hot L or G is treated as "at speed".
    always_comb begin
        dir = ST_HOLD;
        if (L && !EQ && !G)
            dir = ST_ACCEL;
        else if (G && !L && !EQ)
            dir = ST_DECEL;
    end

    // 9-bit arithmetic: bit 8 flags overflow (up) or borrow (down).
    assign up_sum  = {1'b0, throttle_reg} + 9'(STEP);
    assign dn_diff = {1'b0, throttle_reg} - 9'(STEP);
    assign up_sat  = up_sum[8]  ? 8'hFF : up_sum[7:0];
    assign dn_sat  = dn_diff[8] ? 8'h00 : dn_diff[7:0];
    assign cnt_inc = {1'b0, cnt_reg} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_OFF;
            throttle_reg <= 8'd0;
            cnt_reg      <= 8'd0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    throttle_reg <= 8'd0;
                    cnt_reg      <= 8'd0;
                    if (enable && !brake) begin
                        state_reg    <= ST_HOLD;
                        throttle_reg <= set_thr;
                    end
                end
                ST_HOLD, ST_ACCEL, ST_DECEL: begin
                    if (brake) begin
                        state_reg    <= ST_OFF;
                        throttle_reg <= 8'd0;
                        cnt_reg      <= 8'd0;
                    end else if (!enable) begin
                        cnt_reg <= 8'd0;
`ifdef THROTTLE_SOFT_RELEASE_EN
                        state_reg <= ST_RELEASE;
`else
                        state_reg    <= ST_OFF;
                        throttle_reg <= 8'd0;
`endif
                    end else if (dir != state_reg) begin
                        state_reg <= dir;
                        cnt_reg   <= 8'd1;
                    end else if (cnt_inc < 9'(HOLD)) begin
                        cnt_reg <= cnt_inc[7:0];
                    end else begin
                        cnt_reg <= 8'd0;
                        if (state_reg == ST_ACCEL)
                            throttle_reg <= up_sat;
                        else if (state_reg == ST_DECEL)
                            throttle_reg <= dn_sat;
                    end
                end
`ifdef THROTTLE_SOFT_RELEASE_EN
                ST_RELEASE: begin
                    cnt_reg <= 8'd0;
                    if (brake) begin
                        state_reg    <= ST_OFF;
                        throttle_reg <= 8'd0;
                    end else if (enable) begin
                        state_reg    <= ST_HOLD;
                        throttle_reg <= set_thr;
                    end else begin
                        throttle_reg <= dn_sat;
                        if (dn_sat == 8'd0)
                            state_reg <= ST_OFF;
                    end
                end
`endif
                default: begin
                    state_reg    <= ST_OFF;
                    throttle_reg <= 8'd0;
                    cnt_reg      <= 8'd0;
                end
            endcase
        end
    end

    assign throttle = throttle_reg;
    assign state    = state_reg;
    assign active   = (state_reg == ST_HOLD) || (state_reg == ST_ACCEL) ||
                      (state_reg == ST_DECEL);
    assign at_speed = (state_reg == ST_HOLD);

endmodule
